// File: rtl/fft_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fft_ctrl_pkg                                                               |
// | Shared types and latency helpers for the radix-2^2 SDF FFT sequencer.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package fft_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam int c_FRAME_CNT_W = 16;
    localparam int c_MAX_POINTS  = 256;

    function automatic int cnt_width(input int n);
        return $clog2(n);
    endfunction

    function automatic int num_stages(input int n);
        return $clog2(n) / 2;
    endfunction

    function automatic int bfi_lat(input int n, input int reg_lat, input int s);
        return (n >> (2 * s + 1)) + reg_lat;
    endfunction

    function automatic int bfii_lat(input int n, input int reg_lat, input int s);
        return (n >> (2 * s + 2)) + reg_lat;
    endfunction

    function automatic int stage_off(input int n, input int reg_lat, input int tfm_lat, input int s);
        int d = 0;
        for (int i = 0; i < s; i++) begin
            d += bfi_lat(n, reg_lat, i) + bfii_lat(n, reg_lat, i) + tfm_lat;
        end
        return d;
    endfunction

    function automatic int pipe_lat(input int n, input int reg_lat, input int tfm_lat);
        int last = num_stages(n) - 1;
        return stage_off(n, reg_lat, tfm_lat, last) + bfi_lat(n, reg_lat, last)
             + bfii_lat(n, reg_lat, last);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_seq_ctrl_tw_addr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fft_tw_addr_gen                                                            |
// | Twiddle rom address for one stage: (bitrev(t[m-1:m-2]) * t[m-3:0]) << 2s.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fft_tw_addr_gen #(
    parameter int T_WIDTH    = 4,
    parameter int SHIFT      = 0,
    parameter int ADDR_WIDTH = 9
) (
    input  logic [T_WIDTH-1:0]    t,
    output logic [ADDR_WIDTH-1:0] addr
);

    logic [1:0]         w_n;
    logic [T_WIDTH-3:0] w_k;
    logic [T_WIDTH-1:0] w_prod;

    assign w_n    = {t[T_WIDTH-2], t[T_WIDTH-1]};
    assign w_k    = t[T_WIDTH-3:0];
    // 3 * (2^(m-2) - 1) always fits in m bits
    assign w_prod = T_WIDTH'(w_n) * T_WIDTH'(w_k);
    assign addr   = ADDR_WIDTH'(w_prod) << SHIFT;

endmodule
`default_nettype wire

// File: rtl/fft_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fft_seq_ctrl                                                               |
// | Sequencer for the radix-2^2 SDF FFT: handshakes, stage control, twiddle    |
// | addressing, output framing and drain. Optional FFT_SEQ_FRAME_CNT_EN adds   |
// | a completed-frame counter on frame_cnt.                                    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fft_seq_ctrl
    import fft_ctrl_pkg::*;
#(
    parameter int N_POINTS   = 16,
    parameter int ADDR_WIDTH = 9,
    parameter int REG_LAT    = 1,
    parameter int TFM_LAT    = 2,
    localparam int c_S       = num_stages(N_POINTS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic                      in_last,
    output logic                      in_ready,
    input  logic                      out_ready,
    output logic                      dp_en,
    output logic [c_S-1:0]            bfi_ctrl,
    output logic [c_S-1:0]            bfii_ctrl1,
    output logic [c_S-1:0]            bfii_ctrl2,
    output logic [c_S-1:0]            tw_rd_en,
    output logic [c_S*ADDR_WIDTH-1:0] tw_addr,
    output logic                      out_valid,
    output logic                      out_sop,
    output logic                      out_eop,
    output logic                      busy,
    output logic [c_FRAME_CNT_W-1:0]  frame_cnt
);

    localparam int c_L        = cnt_width(N_POINTS);
    localparam int c_PIPE_LAT = pipe_lat(N_POINTS, REG_LAT, TFM_LAT);
    localparam int c_DW       = $clog2(c_PIPE_LAT + 1);

    state_t          r_state, w_state_nxt;
    logic [c_L-1:0]  r_cnt, r_ocnt;
    logic [c_DW-1:0] r_fill, r_drain;
    logic            w_accept, w_dp_en, w_flush_done, w_ctrl_on, w_out_valid;

    assign in_ready = out_ready && (r_state != ST_FLUSH);

    always_comb begin
        w_accept     = in_valid && in_ready;
        w_dp_en      = (r_state == ST_FLUSH) ? out_ready : w_accept;
        w_flush_done = (r_state == ST_FLUSH) && out_ready
                    && (r_drain == c_DW'(c_PIPE_LAT - 1));
        w_state_nxt  = r_state;
        case (r_state)
            ST_IDLE, ST_RUN: if (w_accept) w_state_nxt = in_last ? ST_FLUSH : ST_RUN;
            ST_FLUSH:        if (w_flush_done) w_state_nxt = ST_IDLE;
            default:         w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_ocnt  <= '0;
            r_fill  <= '0;
            r_drain <= '0;
        end else begin
            r_state <= w_state_nxt;
            // A finished drain realigns every counter so the next run starts on a frame boundary
            if (w_flush_done) begin
                r_cnt   <= '0;
                r_ocnt  <= '0;
                r_fill  <= '0;
                r_drain <= '0;
            end else begin
                if (w_dp_en)     r_cnt  <= r_cnt + 1'b1;
                if (w_out_valid) r_ocnt <= r_ocnt + 1'b1;
                if (r_state == ST_IDLE)
                    r_fill <= w_dp_en ? c_DW'(1) : '0;
                else if (w_dp_en && (r_fill != c_DW'(c_PIPE_LAT)))
                    r_fill <= r_fill + 1'b1;
                if ((r_state == ST_FLUSH) && w_dp_en) r_drain <= r_drain + 1'b1;
            end
        end
    end

    assign dp_en       = w_dp_en;
    assign busy        = (r_state != ST_IDLE);
    assign w_out_valid = w_dp_en && (r_fill == c_DW'(c_PIPE_LAT));
    assign out_valid   = w_out_valid;
    assign out_sop     = w_out_valid && (r_ocnt == '0);
    assign out_eop     = w_out_valid && (r_ocnt == c_L'(N_POINTS - 1));
    // Control outputs only matter while advancing; holding them low when idle keeps reset quiet
    assign w_ctrl_on   = busy || w_dp_en;

    for (genvar s = 0; s < c_S; s++) begin : g_stage
        localparam int c_OFF_C  = stage_off(N_POINTS, REG_LAT, TFM_LAT, s) % N_POINTS;
        localparam int c_OFF_C2 = (stage_off(N_POINTS, REG_LAT, TFM_LAT, s)
                                 + bfi_lat(N_POINTS, REG_LAT, s)) % N_POINTS;

        assign bfi_ctrl[s]   = w_ctrl_on & 1'((r_cnt - c_L'(c_OFF_C))  >> (c_L - 1 - 2 * s));
        assign bfii_ctrl1[s] = w_ctrl_on & 1'((r_cnt - c_L'(c_OFF_C2)) >> (c_L - 1 - 2 * s));
        assign bfii_ctrl2[s] = w_ctrl_on & 1'((r_cnt - c_L'(c_OFF_C2)) >> (c_L - 2 - 2 * s));

        if (s < c_S - 1) begin : g_tw
            localparam int c_OFF_T = (stage_off(N_POINTS, REG_LAT, TFM_LAT, s)
                                    + bfi_lat(N_POINTS, REG_LAT, s)
                                    + bfii_lat(N_POINTS, REG_LAT, s)) % N_POINTS;
            localparam int c_M     = c_L - 2 * s;
            logic [ADDR_WIDTH-1:0] w_addr;

            fft_tw_addr_gen #(
                .T_WIDTH    (c_M),
                .SHIFT      (2 * s),
                .ADDR_WIDTH (ADDR_WIDTH)
            ) u_tw_addr (
                .t    (c_M'(r_cnt - c_L'(c_OFF_T))),
                .addr (w_addr)
            );

            assign tw_rd_en[s]                         = w_dp_en;
            assign tw_addr[s*ADDR_WIDTH +: ADDR_WIDTH] = w_ctrl_on ? w_addr : '0;
        end else begin : g_no_tw
            assign tw_rd_en[s]                         = 1'b0;
            assign tw_addr[s*ADDR_WIDTH +: ADDR_WIDTH] = '0;
        end
    end

`ifdef FFT_SEQ_FRAME_CNT_EN
    logic [c_FRAME_CNT_W-1:0] r_frame_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         r_frame_cnt <= '0;
        else if (out_eop) r_frame_cnt <= r_frame_cnt + 1'b1;
    end

    assign frame_cnt = r_frame_cnt;
`else
    assign frame_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fft_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fft_seq_ctrl                                                            |
// | Directed scoreboard bench for fft_seq_ctrl at the default 16-point config. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_fft_seq_ctrl;

    localparam int N  = 16;
    localparam int PL = 21;
    localparam int AW = 9;
    localparam int S  = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
    logic          in_ready, dp_en, out_valid, out_sop, out_eop, busy;
    logic [S-1:0]  bfi_ctrl, bfii_ctrl1, bfii_ctrl2, tw_rd_en;
    logic [S*AW-1:0] tw_addr;
    logic [15:0]   frame_cnt;

    always #5 clk = ~clk;

    fft_seq_ctrl #(
        .N_POINTS   (N),
        .ADDR_WIDTH (AW),
        .REG_LAT    (1),
        .TFM_LAT    (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .out_ready  (out_ready),
        .dp_en      (dp_en),
        .bfi_ctrl   (bfi_ctrl),
        .bfii_ctrl1 (bfii_ctrl1),
        .bfii_ctrl2 (bfii_ctrl2),
        .tw_rd_en   (tw_rd_en),
        .tw_addr    (tw_addr),
        .out_valid  (out_valid),
        .out_sop    (out_sop),
        .out_eop    (out_eop),
        .busy       (busy),
        .frame_cnt  (frame_cnt)
    );

    typedef struct {
        int   idx;
        logic sop;
        logic eop;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   m_dp   = 0;
    int   tw_tab [16] = '{0, 0, 0, 0, 0, 2, 4, 6, 0, 1, 2, 3, 0, 3, 6, 9};
    logic [3:0] c, c2a, c2b, t0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_frames(input int n);
`ifdef FFT_SEQ_FRAME_CNT_EN
        return n;
`else
        return 0 * n;
`endif
    endfunction

    // Monitor: control bits on every advance, scoreboard pop on every output
    always @(negedge clk) begin
        if (!rst) begin
            m_dp = 0;
        end else begin
            if (!out_ready) begin
                chk("stall_in_ready", in_ready, 0);
                chk("stall_dp_en", dp_en, 0);
            end
            if (out_valid && !dp_en) chk("valid_without_dp_en", out_valid, 0);
            if (dp_en) begin
                c   = m_dp[3:0];
                c2a = c - 4'd9;
                c2b = c - 4'd3;
                t0  = c - 4'd14;
                chk("bfi_ctrl", bfi_ctrl, {c[1], c[3]});
                chk("bfii_ctrl1", bfii_ctrl1, {c2b[1], c2a[3]});
                chk("bfii_ctrl2", bfii_ctrl2, {c2b[0], c2a[2]});
                chk("tw_rd_en", tw_rd_en, 2'b01);
                chk("tw_addr", tw_addr, tw_tab[t0]);
                if (out_valid) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_out_valid", out_valid, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("out_dp_index", m_dp, e.idx);
                        chk("out_sop", out_sop, e.sop);
                        chk("out_eop", out_eop, e.eop);
                    end
                end
                m_dp++;
            end
        end
    end

    task automatic do_reset();
        rst = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        sb.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic send(input int nsamp, input bit last, input bit stall);
        int   j = 0;
        int   budget = 0;
        logic acc;
        @(posedge clk); #1;
        while (j < nsamp && budget < 2000) begin
            in_valid  = 1'b1;
            in_last   = last && (j == nsamp - 1);
            out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            if (acc) begin
                sb.push_back(exp_t'{j + PL, (j % N) == 0, (j % N) == N - 1});
                j++;
            end
            budget++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (j < nsamp) chk("send_timeout", j, nsamp);
    endtask

    task automatic finish_run(input int nsamp, input bit stall, input int frames);
        int budget = 0;
        while (busy && budget < 1000) begin
            out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
            budget++;
        end
        out_ready = 1'b1;
        chk("returned_to_idle", busy, 0);
        chk("total_dp_en", m_dp, nsamp + PL);
        chk("scoreboard_empty", sb.size(), 0);
        chk("frame_cnt", frame_cnt, exp_frames(frames));
    endtask

    initial begin
        // Reset / idle
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_dp_en", dp_en, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tw_addr", tw_addr, 0);
        chk("rst_tw_rd_en", tw_rd_en, 0);
        chk("rst_ctrl", {bfi_ctrl, bfii_ctrl1, bfii_ctrl2}, 0);
        chk("rst_markers", {out_sop, out_eop}, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        do_reset();
        #2;
        chk("idle_in_ready", in_ready, 1);
        chk("idle_busy", busy, 0);

        // Single frame
        send(16, 1'b1, 1'b0);
        finish_run(16, 1'b0, 1);

        // Three back-to-back frames
        do_reset();
        send(48, 1'b1, 1'b0);
        finish_run(48, 1'b0, 3);

        // Backpressure during run and drain
        do_reset();
        send(32, 1'b1, 1'b1);
        finish_run(32, 1'b1, 2);

        // Last flag off a frame boundary: partial second frame, no eop
        do_reset();
        send(20, 1'b1, 1'b0);
        finish_run(20, 1'b0, 1);

        // Reset mid-frame, then a clean frame
        do_reset();
        send(7, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_dp_en", dp_en, 0);
        do_reset();
        send(16, 1'b1, 1'b0);
        finish_run(16, 1'b0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/fft_seq_ctrl.md
Name: fft_seq_ctrl

Overview:
- Sequencer for the radix-2^2 SDF FFT pipeline (bfi -> bfii -> tfm per stage, twiddle rom per stage).
- Owns the input/output handshakes and the global sample counter.
- Generates the pipeline enable, per-stage butterfly control bits, twiddle rom addresses and read enables, output valid and frame markers.
- Drains the pipeline after the last frame.

Parameters:
- N_POINTS, 16, FFT size; a power of 4, 16..256.
- ADDR_WIDTH, 9, twiddle rom address width.
- REG_LAT, 1, output register latency of each bfi/bfii.
- TFM_LAT, 2, tfm latency in en-cycles, including the rom read.
- Derived:
  - L = log2(N_POINTS); S = L/2 stages.
  - BFI_LAT(s) = N_POINTS/2^(2s+1) + REG_LAT.
  - BFII_LAT(s) = N_POINTS/2^(2s+2) + REG_LAT.
  - D(0) = 0; D(s+1) = D(s) + BFI_LAT(s) + BFII_LAT(s) + TFM_LAT.
  - PIPE_LAT = D(S-1) + BFI_LAT(S-1) + BFII_LAT(S-1). Equals 21 for the defaults.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  input sample valid
- in_last  in  1  marks the final sample of the final frame
- in_ready  out  1  controller accepts a sample
- out_ready  in  1  downstream can accept a sample
- dp_en  out  1  pipeline advance enable to all bfi/bfii/tfm
- bfi_ctrl  out  S  bfi control bit, one per stage
- bfii_ctrl1  out  S  bfii control1 bit, one per stage
- bfii_ctrl2  out  S  bfii control2 bit, one per stage
- tw_rd_en  out  S  rom read enable, one per stage
- tw_addr  out  S*ADDR_WIDTH  rom address, one per stage
- out_valid  out  1  pipeline output sample valid
- out_sop  out  1  first output sample of a frame
- out_eop  out  1  last output sample of a frame
- busy  out  1  state != IDLE
- frame_cnt  out  16  completed output frames (optional feature)

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE; all counters = 0.
  - All outputs 0 except in_ready = 1.
  - Reset mid-frame discards in-flight samples; no partial frame is reported.
- FSM states: IDLE, RUN, FLUSH.
  - IDLE -> RUN on an accepted sample.
  - RUN -> FLUSH on an accepted sample with in_last = 1.
  - FLUSH -> IDLE when the drain counter reaches PIPE_LAT.
- in_ready = out_ready && state != FLUSH.
- dp_en (combinational):
  - IDLE/RUN: in_valid && in_ready.
  - FLUSH: out_ready.
  - Drain samples are don't-care data.
- Counter cnt, L bits:
  - Increments on dp_en and wraps N_POINTS-1 -> 0.
  - Not reset between frames; frames are back-to-back.
- Stage timing counters (mod N_POINTS):
  - Stage counter c_s = cnt - D(s).
  - bfi_ctrl[s] = c_s[L-1-2s].
  - c2_s = cnt - D(s) - BFI_LAT(s).
  - bfii_ctrl1[s] = c2_s[L-1-2s]; bfii_ctrl2[s] = c2_s[L-2-2s].
- Twiddle address:
  - Stage counter t_s = cnt - D(s) - BFI_LAT(s) - BFII_LAT(s); m = L - 2s.
  - n = bit-reverse of t_s[m-1:m-2]; k = t_s[m-3:0].
  - tw_addr[s] = (n*k) << 2s, zero-extended to ADDR_WIDTH.
- Twiddle enables:
  - tw_rd_en[s] = dp_en for s < S-1.
  - tw_rd_en[S-1] = 0 and tw_addr[S-1] = 0; the last stage has no twiddle.
- Fill counter:
  - Counts dp_en cycles since leaving IDLE and saturates at PIPE_LAT.
  - out_valid = dp_en && fill == PIPE_LAT. The first valid output is on the (PIPE_LAT+1)-th dp_en of a run.
- Output counter ocnt, L bits:
  - Advances on out_valid.
  - out_sop = out_valid && ocnt == 0; out_eop = out_valid && ocnt == N_POINTS-1.
- FLUSH:
  - Drain counter counts dp_en cycles.
  - Exactly PIPE_LAT dp_en cycles complete the last frame, then the FSM returns to IDLE.
  - The fill counter clears in IDLE.
- in_last on a non-frame-boundary sample:
  - Still flushes.
  - The partial output frame emits without out_eop.
- Stalls: out_ready low freezes every counter and control output; there is no sample loss.

Optional Feature:
- Macro FFT_SEQ_FRAME_CNT_EN.
- Defined: frame_cnt increments on out_eop, wraps at 2^16, and clears on reset.
- Undefined: frame_cnt tied to 0 and its counter logic is absent.

Decomposition:
- Package fft_ctrl_pkg:
  - State enum (IDLE/RUN/FLUSH).
  - Functions bfi_lat(s), bfii_lat(s), stage_off(s) and pipe_lat(N, REG_LAT, TFM_LAT).
  - Width constants derived from N_POINTS.
- Sub-module fft_tw_addr_gen: per-stage twiddle address from t_s; one instance per stage via generate.

Test Plan:
- Reset/idle: hold rst low, then release -> in_ready = 1, dp_en = 0, out_valid = 0, busy = 0, all tw_addr = 0.
- Single frame (N = 16, defaults):
  - Stimulus: 16 samples, continuous valid, in_last on the 16th.
  - Required: first out_valid on dp_en #22; out_sop then, out_eop 15 cycles later; FLUSH lasts 21 dp_en cycles, then IDLE.
- Control bits:
  - Stimulus: cnt sequence 0..15, N = 16.
  - Required: bfi_ctrl[0] = cnt[3] undelayed; bfii_ctrl1[0] = bit3 of (cnt-9); bfii_ctrl2[0] = bit2 of (cnt-9).
  - Required: tw_addr[0] at t_0 = 13 (n = bit-reverse(3) = 3, k = 1) equals 3.
- Back-to-back frames:
  - Stimulus: 3 frames, no gaps.
  - Required: 48 contiguous out_valid; out_sop at 0/16/32; frame_cnt = 3 with FFT_SEQ_FRAME_CNT_EN, 0 without.
- Backpressure: toggle out_ready 50% during RUN and FLUSH -> in_ready and dp_en low while out_ready is low; output count and markers identical to the unstalled run.
- Reset mid-frame: assert rst after 7 samples -> immediate IDLE, no out_valid; a subsequent full frame behaves as in the single-frame case.
